// File: rtl/button_conditioner.sv
// button_conditioner: synchronises and debounces the two active-low theta step
// buttons and turns each accepted press into a one-cycle strobe.
// Optional hold-to-repeat is compiled in when BUTTON_AUTOREPEAT_EN is defined;
// without it each accepted press yields exactly one strobe.

// One button channel: 2-FF synchroniser, stable-count debounce, strobe FSM.
module button_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
`ifdef BUTTON_AUTOREPEAT_EN
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
`endif
    parameter int unsigned CNT_W           = 26
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic raw_n,
    input  logic other_held,
    output logic held,
    output logic strobe
);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             held_d;
    logic [CNT_W-1:0] db_cnt;
    logic             pressed_sync;
    logic             flip_c;
    logic             release_c;
    logic             press_edge_c;

    assign pressed_sync = ~sync_q2;
    assign flip_c       = (pressed_sync != held) && (db_cnt == DB_LAST);
    // Release flip is acted on in the same cycle so a repeat due now is dropped.
    assign release_c    = flip_c && held;
    assign press_edge_c = held && !held_d;

    // Two-stage synchroniser; resets to the released (high) level.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= raw_n;
            sync_q2 <= sync_q1;
        end
    end

    // Stable-count filter: level accepted only after DEBOUNCE_CYCLES differing cycles.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            db_cnt <= '0;
            held   <= 1'b0;
            held_d <= 1'b0;
        end else begin
            held_d <= held;
            if (pressed_sync == held) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                held   <= pressed_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    state_t           state;
    logic [CNT_W-1:0] timer;

    // Press strobe, then repeat strobes; frozen while the other button is held.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state  <= IDLE;
            timer  <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (!held || release_c) begin
                state <= IDLE;
                timer <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (press_edge_c && !other_held) begin
                            state  <= DELAY;
                            timer  <= '0;
                            strobe <= 1'b1;
                        end
                    end
                    DELAY: begin
                        if (!other_held) begin
                            if (timer == RD_LAST) begin
                                state  <= REPEAT;
                                timer  <= '0;
                                strobe <= 1'b1;
                            end else begin
                                timer <= timer + CNT_W'(1);
                            end
                        end
                    end
                    REPEAT: begin
                        if (!other_held) begin
                            if (timer == RP_LAST) begin
                                timer  <= '0;
                                strobe <= 1'b1;
                            end else begin
                                timer <= timer + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end
`else
    typedef enum logic {IDLE, PRESSED} state_t;

    state_t state;

    // One strobe per accepted press; a press seen while the other is held is ignored.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state  <= IDLE;
            strobe <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (!held || release_c) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (press_edge_c && !other_held) begin
                            state  <= PRESSED;
                            strobe <= 1'b1;
                        end
                    end
                    PRESSED: state <= PRESSED;
                endcase
            end
        end
    end
`endif

endmodule

// Top: increase and decrease channels cross-coupled for mutual exclusion.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_increase,
    input  logic       i_decrease,
    output logic       o_inc,
    output logic       o_dec,
    output logic [1:0] o_held
);
    localparam longint unsigned CNT_SPAN = 64'(1) << CNT_W;

    // Counters must hold every configured terminal count.
    if ((CNT_SPAN <= 64'(DEBOUNCE_CYCLES)) || (CNT_SPAN <= 64'(REPEAT_DELAY)) ||
        (CNT_SPAN <= 64'(REPEAT_PERIOD))) begin : g_cnt_w_check
        $error("button_conditioner: CNT_W too small for configured cycle counts");
    end

    logic held_inc;
    logic held_dec;

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef BUTTON_AUTOREPEAT_EN
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
        .CNT_W           (CNT_W)
    ) u_inc (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .raw_n      (i_increase),
        .other_held (held_dec),
        .held       (held_inc),
        .strobe     (o_inc)
    );

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef BUTTON_AUTOREPEAT_EN
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
        .CNT_W           (CNT_W)
    ) u_dec (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .raw_n      (i_decrease),
        .other_held (held_inc),
        .held       (held_dec),
        .strobe     (o_dec)
    );

    assign o_held = {held_inc, held_dec};

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8). Expected strobes are queued when stimulus is applied and
// matched against DUT strobes as they appear.
module tb_button_conditioner;
    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 20;
    localparam int unsigned RP  = 8;
    localparam int unsigned CW  = 8;
    localparam logic [1:0] CH_INC = 2'b10;
    localparam logic [1:0] CH_DEC = 2'b01;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inc_n;
    logic       dec_n;
    logic       o_inc;
    logic       o_dec;
    logic [1:0] o_held;

    longint cyc = 0;
    int     n_tests = 0;
    int     n_fail  = 0;

    typedef struct {
        longint     cyc;
        logic [1:0] ch;
    } exp_t;

    exp_t exp_q[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .CNT_W           (CW)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_increase (inc_n),
        .i_decrease (dec_n),
        .o_inc      (o_inc),
        .o_dec      (o_dec),
        .o_held     (o_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_strobe(input longint t, input logic [1:0] ch);
        exp_t e;
        e.cyc = t;
        e.ch  = ch;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input longint t);
        while (cyc < t) @(negedge clk);
    endtask

    // Strobe monitor: every DUT strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (o_inc || o_dec) begin
            check("strobe_excl", 64'(o_inc & o_dec), 64'(0));
            if (exp_q.size() == 0) begin
                check("spurious_strobe", 64'({o_inc, o_dec}), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_cycle", 64'(cyc), 64'(e.cyc));
                check("strobe_channel", 64'({o_inc, o_dec}), 64'(e.ch));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        longint     c;
        longint     r;
        logic [1:0] held_or;

        rst_n = 1'b0;
        inc_n = 1'b1;
        dec_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_inc", 64'(o_inc), 64'(0));
        check("reset_dec", 64'(o_dec), 64'(0));
        check("reset_held", 64'(o_held), 64'(0));
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Bounce: 3-cycle low/high pulses never qualify.
        held_or = 2'b00;
        for (int i = 0; i < 40; i++) begin
            inc_n = (((i / 3) % 2) == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            held_or = held_or | o_held;
        end
        inc_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            held_or = held_or | o_held;
        end
        check("bounce_held", 64'(held_or), 64'(0));

        // Clean press of increase for 10 cycles.
        c = cyc;
        inc_n = 1'b0;
        expect_strobe(c + 7, CH_INC);
        wait_until(c + 5);
        check("press_held_before", 64'(o_held), 64'(2'b00));
        wait_until(c + 6);
        check("press_held_rise", 64'(o_held), 64'(2'b10));
        wait_until(c + 10);
        inc_n = 1'b1;
        r = cyc;
        wait_until(r + 5);
        check("release_held_before", 64'(o_held), 64'(2'b10));
        wait_until(r + 6);
        check("release_held_fall", 64'(o_held), 64'(2'b00));
        wait_until(r + 20);
        check("press_pending", 64'(exp_q.size()), 64'(0));

        // Decrease held for 60 cycles: press strobe plus repeats when enabled.
        c = cyc;
        dec_n = 1'b0;
        expect_strobe(c + 7, CH_DEC);
`ifdef BUTTON_AUTOREPEAT_EN
        for (int k = 0; k < 5; k++) expect_strobe(c + 7 + RD + k * RP, CH_DEC);
`endif
        wait_until(c + 60);
        dec_n = 1'b1;
        wait_until(c + 90);
        check("repeat_pending", 64'(exp_q.size()), 64'(0));
        check("repeat_held_end", 64'(o_held), 64'(2'b00));

        // Both pressed in the same cycle: levels show, no strobes.
        c = cyc;
        inc_n = 1'b0;
        dec_n = 1'b0;
        wait_until(c + 5);
        check("simul_held_before", 64'(o_held), 64'(2'b00));
        wait_until(c + 6);
        check("simul_held", 64'(o_held), 64'(2'b11));
        wait_until(c + 40);
        inc_n = 1'b1;
        dec_n = 1'b1;
        wait_until(c + 60);
        check("simul_held_end", 64'(o_held), 64'(2'b00));

        // Lockout: increase held, decrease pressed 10 cycles later for 15 cycles.
        c = cyc;
        inc_n = 1'b0;
        expect_strobe(c + 7, CH_INC);
`ifdef BUTTON_AUTOREPEAT_EN
        // Timer frozen for the 15 cycles both stable levels are pressed.
        expect_strobe(c + 7 + RD + 15, CH_INC);
        expect_strobe(c + 7 + RD + 15 + RP, CH_INC);
        expect_strobe(c + 7 + RD + 15 + 2 * RP, CH_INC);
`endif
        wait_until(c + 10);
        dec_n = 1'b0;
        wait_until(c + 20);
        check("lockout_both_held", 64'(o_held), 64'(2'b11));
        wait_until(c + 25);
        dec_n = 1'b1;
        wait_until(c + 40);
        check("lockout_inc_only", 64'(o_held), 64'(2'b10));
        wait_until(c + 55);
        inc_n = 1'b1;
        wait_until(c + 80);
        check("lockout_pending", 64'(exp_q.size()), 64'(0));

        // Reset pulse during a held increase.
        c = cyc;
        inc_n = 1'b0;
        expect_strobe(c + 7, CH_INC);
        wait_until(c + 15);
        rst_n = 1'b0;
        wait_until(c + 16);
        check("midrst_inc", 64'(o_inc), 64'(0));
        check("midrst_dec", 64'(o_dec), 64'(0));
        check("midrst_held", 64'(o_held), 64'(0));
        wait_until(c + 17);
        rst_n = 1'b1;
        expect_strobe(c + 17 + 7, CH_INC);
        wait_until(c + 23);
        check("midrst_held_rise", 64'(o_held), 64'(2'b10));
        wait_until(c + 35);
        inc_n = 1'b1;
        wait_until(c + 60);
        check("midrst_pending", 64'(exp_q.size()), 64'(0));
        check("final_held", 64'(o_held), 64'(2'b00));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioner for the two active-low push buttons that step the converter phase angle θ. It synchronises each raw button to `i_clk` and debounces it with a stable-count filter. Each qualified press becomes a single-cycle strobe, with optional hold-to-repeat. The θ control stage downstream consumes these strobes synchronously, one ±5° step per strobe, instead of clocking on raw button edges.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms @ 50 MHz).
- `REPEAT_DELAY`, default 25000000: cycles from the press strobe to the first repeat strobe (500 ms).
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent repeat strobes (100 ms).
- `CNT_W`, default 26: counter width. Must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- `i_clk`, input, 1: system clock.
- `i_reset`, input, 1: reset, asynchronous, active-low.
- `i_increase`, input, 1: raw increase button, active-low, asynchronous.
- `i_decrease`, input, 1: raw decrease button, active-low, asynchronous.
- `o_inc`, output, 1: increase strobe, active-high, one cycle wide.
- `o_dec`, output, 1: decrease strobe, active-high, one cycle wide.
- `o_held`, output, 2: debounced pressed levels, active-high. Bit 1 is increase, bit 0 is decrease.

## Operation
- Two identical channels (INC, DEC). Each has a 2-FF synchroniser, a debounce counter, a stable level, and a repeat timer.
- Synchroniser flops reset to 1 (released).
- Debounce, per channel:
  - Synchronised level equal to the stable level: counter clears to 0.
  - Synchronised level differs: counter increments.
  - Counter = DEBOUNCE_CYCLES−1 while still differing: stable level takes the synchronised value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is discarded.
- Per-channel FSM, states IDLE, DELAY, REPEAT:
  - IDLE → DELAY on the stable press edge. Emits the press strobe and clears the repeat timer.
  - DELAY: timer counts. At REPEAT_DELAY−1 it emits a strobe, goes to REPEAT, and clears the timer.
  - REPEAT: at REPEAT_PERIOD−1 it emits a strobe and clears the timer.
  - Stable release from any state → IDLE, timer cleared, no strobe.
- Mutual exclusion:
  - A press edge whose channel sees the other channel's stable level already pressed is ignored. The channel stays IDLE until released.
  - Press edges on both channels in the same cycle: both channels stay IDLE and no strobe is emitted.
  - While both are held, repeat strobes are suppressed and timers are frozen.
  - `o_inc` and `o_dec` are never high in the same cycle.
- Reset mid-press: all state returns to released/IDLE. A button still held after reset release produces one press strobe after the normal debounce latency.
- `o_held` mirrors the stable levels and is unaffected by lockout.

## Timing
- Reset values: `o_inc`=0, `o_dec`=0, `o_held`=2'b00. Counters 0, FSMs IDLE, stable levels released.
- Press latency, measured from the first `i_clk` edge sampling the new input level:
  - Synchronised level changes after 2 edges.
  - Stable level flips DEBOUNCE_CYCLES edges later.
  - Registered strobe is high on the following cycle.
  - Total: strobe high DEBOUNCE_CYCLES+3 edges after the first sampling edge.
- `o_held` changes one cycle before the corresponding press strobe.
- Repeat strobes are spaced exactly REPEAT_DELAY cycles (first) and REPEAT_PERIOD cycles (subsequent) from the previous strobe.
- Release latency is DEBOUNCE_CYCLES+2 edges to `o_held` clearing. A pending repeat strobe due in the same cycle as the release flip is dropped.
- All outputs are registered; there are no combinational paths from inputs.

## Configuration
- `BUTTON_AUTOREPEAT_EN` defined: the DELAY/REPEAT behaviour is compiled in as described above.
- Undefined: the repeat timers are not built. The FSM reduces to IDLE/PRESSED, with exactly one strobe per accepted press. REPEAT_DELAY and REPEAT_PERIOD are unused.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Bounce rejection:
  - Stimulus: `i_increase` toggles low/high with 3-cycle pulses for 40 cycles, then goes high.
  - Required: no `o_inc`, `o_held` stays 00.
- Clean press:
  - Stimulus: `i_increase` held low for 10 cycles, then high.
  - Required: one `o_inc` pulse 7 edges after the first low sample. `o_held[1]` rises one cycle before the pulse and falls 6 edges after release.
- Auto-repeat (macro defined):
  - Stimulus: `i_decrease` held low for 60 cycles.
  - Required: `o_dec` pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52. Nothing after release. With the macro undefined, only the t0 pulse appears.
- Simultaneous press:
  - Stimulus: both buttons go low in the same cycle for 40 cycles.
  - Required: no `o_inc`/`o_dec`, `o_held`=11 after the debounce latency.
- Lockout:
  - Stimulus: `i_increase` held; 10 cycles later `i_decrease` pressed for 15 cycles.
  - Required: no `o_dec` ever; `o_inc` repeats pause while both are held.
- Reset mid-press:
  - Stimulus: `i_reset` pulsed low for 2 cycles during a held `i_increase`.
  - Required: all outputs read 0 during reset. One new `o_inc` pulse appears 7 edges after reset release.
